comparator_nbit_seq: RTL

- Parametrised, sequential successor to the 2-bit magnitude comparator.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, and stops at the first differing chunk.
- Supports unsigned or two's-complement signed comparison, selected per request.
- Uses a start/busy/done handshake and holds its results until the next request; it sits beside ALU and datapath blocks that need area-cheap wide compares.

---
 rtl/comparator_nbit_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/comparator_nbit_seq.sv
// ----------------------------------------------------------------------------
// comparator_nbit_seq
// Sequential WIDTH-bit magnitude comparator. Operands are compared MSB-first,
// CHUNK bits per clock, stopping at the first chunk that differs. Unsigned or
// two's-complement ordering is chosen per request. Results are registered and
// held until the next accepted request or reset.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high, highest priority
//   start        request strobe, accepted only while idle
//   signed_mode  1 = two's-complement compare, 0 = unsigned (sampled at accept)
//   a, b         operands (sampled at accept)
//   busy         high while a compare is in progress
//   done         one-cycle pulse when the result is written
//   result_valid high from done until the next accepted start or reset
//   a_gt_b       A >  B (held)
//   a_eq_b       A == B (held)
//   a_lt_b       A <  B (held)
// ----------------------------------------------------------------------------
module comparator_nbit_seq #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             result_valid,
   output logic             a_gt_b,
   output logic             a_eq_b,
   output logic             a_lt_b
);

   localparam int NCHUNK = WIDTH / CHUNK;
   // Keep the index at least one bit wide so CHUNK == WIDTH still elaborates.
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COMPARE = 1'b1
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [WIDTH-1:0]  a_r, a_nxt_s;
   logic [WIDTH-1:0]  b_r, b_nxt_s;
   logic              signed_r, signed_nxt_s;
   logic [IDXW-1:0]   idx_r, idx_nxt_s;
   logic              busy_r, busy_nxt_s;
   logic              done_r, done_nxt_s;
   logic              valid_r, valid_nxt_s;
   logic              gt_r, gt_nxt_s;
   logic              eq_r, eq_nxt_s;
   logic              lt_r, lt_nxt_s;

   logic [CHUNK-1:0]  chunk_a_s, chunk_b_s;
   logic              decided_s, dec_gt_s, dec_eq_s, dec_lt_s;

   // Select the CHUNK-bit slice at chunk position idx.
   function automatic logic [CHUNK-1:0] get_chunk(input logic [WIDTH-1:0] vec,
                                                  input logic [IDXW-1:0]  idx);
      get_chunk = CHUNK'(vec >> (int'(idx) * CHUNK));
   endfunction

   assign chunk_a_s = get_chunk(a_r, idx_r);
   assign chunk_b_s = get_chunk(b_r, idx_r);

   // Decide the current chunk: sign override on the top chunk, else unsigned slice compare.
   always_comb begin
      decided_s = 1'b0;
      dec_gt_s  = 1'b0;
      dec_eq_s  = 1'b0;
      dec_lt_s  = 1'b0;
      // Differing sign bits settle a signed compare before any magnitude bits matter.
      if (signed_r && (idx_r == IDXW'(NCHUNK - 1)) && (a_r[WIDTH-1] != b_r[WIDTH-1])) begin
         decided_s = 1'b1;
         dec_lt_s  = a_r[WIDTH-1];
         dec_gt_s  = ~a_r[WIDTH-1];
      end else if (chunk_a_s > chunk_b_s) begin
         decided_s = 1'b1;
         dec_gt_s  = 1'b1;
      end else if (chunk_a_s < chunk_b_s) begin
         decided_s = 1'b1;
         dec_lt_s  = 1'b1;
      end else if (idx_r == {IDXW{1'b0}}) begin
         decided_s = 1'b1;
         dec_eq_s  = 1'b1;
      end else begin
         decided_s = 1'b0;
      end
   end

   // Next-state and next-output logic for the IDLE/COMPARE controller.
   always_comb begin
      state_nxt_s  = state_r;
      a_nxt_s      = a_r;
      b_nxt_s      = b_r;
      signed_nxt_s = signed_r;
      idx_nxt_s    = idx_r;
      busy_nxt_s   = busy_r;
      done_nxt_s   = 1'b0;
      valid_nxt_s  = valid_r;
      gt_nxt_s     = gt_r;
      eq_nxt_s     = eq_r;
      lt_nxt_s     = lt_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s  = COMPARE;
               a_nxt_s      = a;
               b_nxt_s      = b;
               signed_nxt_s = signed_mode;
               idx_nxt_s    = IDXW'(NCHUNK - 1);
               busy_nxt_s   = 1'b1;
               valid_nxt_s  = 1'b0;
               gt_nxt_s     = 1'b0;
               eq_nxt_s     = 1'b0;
               lt_nxt_s     = 1'b0;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         COMPARE: begin
            if (decided_s) begin
               state_nxt_s = IDLE;
               busy_nxt_s  = 1'b0;
               done_nxt_s  = 1'b1;
               valid_nxt_s = 1'b1;
               gt_nxt_s    = dec_gt_s;
               eq_nxt_s    = dec_eq_s;
               lt_nxt_s    = dec_lt_s;
            end else begin
               idx_nxt_s = idx_r - IDXW'(1);
            end
         end
         default: begin
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
         end
      endcase
   end

   // State, operand and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         signed_r <= 1'b0;
         idx_r    <= {IDXW{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         valid_r  <= 1'b0;
         gt_r     <= 1'b0;
         eq_r     <= 1'b0;
         lt_r     <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         a_r      <= a_nxt_s;
         b_r      <= b_nxt_s;
         signed_r <= signed_nxt_s;
         idx_r    <= idx_nxt_s;
         busy_r   <= busy_nxt_s;
         done_r   <= done_nxt_s;
         valid_r  <= valid_nxt_s;
         gt_r     <= gt_nxt_s;
         eq_r     <= eq_nxt_s;
         lt_r     <= lt_nxt_s;
      end
   end

   assign busy         = busy_r;
   assign done         = done_r;
   assign result_valid = valid_r;
   assign a_gt_b       = gt_r;
   assign a_eq_b       = eq_r;
   assign a_lt_b       = lt_r;

endmodule
